// File: rtl/ddrphy_bclk_train_ctrl.sv
// BCLK training controller for the DDR4 PHY IOD lanes.
// Each lane in turn: sweep the RX delay line one tap at a time and classify
// every tap as stable or unstable. The stable word seen first is the
// reference. The first tap that no longer shows the reference opens the
// transition region (E1). The first stable tap after that with a different
// word closes it (E2). The lane is then reloaded and stepped forward to the
// middle of [E1, E2].
module ddrphy_bclk_train_ctrl #(
  parameter int NUM_LANES     = 2,
  parameter int RX_WIDTH      = 8,
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 16,
  localparam int TAP_W        = $clog2(MAX_TAPS)
) (
  input  logic                          FAB_CLK,
  input  logic                          RESET_N,
  input  logic                          TRAIN_START,
  output logic                          TRAIN_BUSY,
  output logic                          TRAIN_DONE,
  output logic [NUM_LANES-1:0]          LANE_PASS,
  output logic [NUM_LANES*TAP_W-1:0]    LANE_TAP,
  input  logic [NUM_LANES*RX_WIDTH-1:0] RX_DATA,
  input  logic [NUM_LANES-1:0]          EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]          EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]          EYE_MONITOR_CLEAR_FLAGS
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SC_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int SM_W   = $clog2(SAMPLES);

  localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(MAX_TAPS - 1);
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SM_W-1:0]   SMP_LAST    = SM_W'(SAMPLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL,
    S_STEP, S_RELOAD, S_MOVE_TO, S_NEXT_LANE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane;
  logic [TAP_W-1:0]    tap;
  logic [SC_W-1:0]     settle_cnt;
  logic [SM_W-1:0]     smp_cnt;
  logic [RX_WIDTH-1:0] w0;
  logic                mismatch;
  logic                flag_seen;
  logic                r_valid;
  logic [RX_WIDTH-1:0] r_word;
  logic                e1_valid;
  logic [TAP_W-1:0]    e1_tap;
  logic [TAP_W-1:0]    target;
  logic                fail;
  logic [TAP_W-1:0]    mv_cnt;
  logic [SC_W-1:0]     mv_wait;
  logic [NUM_LANES-1:0] pass_q;
  logic [TAP_W-1:0]    tap_arr [NUM_LANES];

  logic [RX_WIDTH-1:0] rx_arr [NUM_LANES];
  logic [RX_WIDTH-1:0] rx_act;
  logic                oor_act;
  logic                flag_act;
  logic                tap_stable;
  logic                e2_hit;
  logic                mv_pulse;
  logic                ld_pulse;
  logic                clr_pulse;
  logic                fail_set;
  logic [NUM_LANES-1:0] lane_sel;

  // Midpoint of the transition region, floor, computed one bit wider
  function automatic logic [TAP_W-1:0] midpoint(input logic [TAP_W-1:0] e1,
                                                input logic [TAP_W-1:0] e2);
    logic [TAP_W:0] diff;
    logic [TAP_W:0] sum;
    diff = {1'b0, e2} - {1'b0, e1};
    sum  = {1'b0, e1} + (diff >> 1);
    return sum[TAP_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rx_arr[g]                  = RX_DATA[g*RX_WIDTH +: RX_WIDTH];
    assign LANE_TAP[g*TAP_W +: TAP_W] = tap_arr[g];
  end

  assign rx_act     = rx_arr[lane];
  assign oor_act    = DELAY_LINE_OUT_OF_RANGE[lane];
  assign flag_act   = EYE_MONITOR_EARLY[lane] | EYE_MONITOR_LATE[lane];
  assign tap_stable = !mismatch && !flag_seen;
  assign e2_hit     = r_valid && e1_valid && tap_stable && (w0 != r_word);
  assign lane_sel   = NUM_LANES'(1) << lane;

  assign TRAIN_BUSY              = (state != S_IDLE) && (state != S_DONE);
  assign TRAIN_DONE              = (state == S_DONE);
  assign LANE_PASS               = pass_q;
  assign DELAY_LINE_MOVE         = mv_pulse  ? lane_sel : '0;
  assign DELAY_LINE_LOAD         = ld_pulse  ? lane_sel : '0;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_pulse ? lane_sel : '0;
  assign DELAY_LINE_DIRECTION    = TRAIN_BUSY ? lane_sel : '0;

  // Next-state and pulse decode; out-of-range aborts the lane from any sweep state
  always_comb begin
    state_nxt = state;
    mv_pulse  = 1'b0;
    ld_pulse  = 1'b0;
    clr_pulse = 1'b0;
    fail_set  = 1'b0;
    case (state)
      S_IDLE: if (TRAIN_START) state_nxt = S_LOAD;
      S_LOAD: begin
        ld_pulse = 1'b1;
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clr_pulse = 1'b1;
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else if (smp_cnt == SMP_LAST) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else if (e2_hit) state_nxt = S_RELOAD;
        else if (tap == TAP_LAST) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else state_nxt = S_STEP;
      end
      S_STEP: begin
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else begin mv_pulse = 1'b1; state_nxt = S_CLEAR; end
      end
      S_RELOAD: begin
        ld_pulse = 1'b1;
        if (fail || oor_act) begin fail_set = 1'b1; state_nxt = S_NEXT_LANE; end
        else state_nxt = S_MOVE_TO;
      end
      S_MOVE_TO: begin
        if (oor_act) begin fail_set = 1'b1; state_nxt = S_RELOAD; end
        else if (mv_cnt == target) state_nxt = S_NEXT_LANE;
        else if (mv_wait == '0) mv_pulse = 1'b1;
      end
      S_NEXT_LANE: state_nxt = (lane == LANE_LAST) ? S_DONE : S_LOAD;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register, sweep bookkeeping, edge search and per-lane results
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      lane       <= '0;
      fail       <= 1'b0;
      r_valid    <= 1'b0;
      e1_valid   <= 1'b0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      mv_cnt     <= '0;
      mv_wait    <= '0;
      pass_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) tap_arr[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (TRAIN_START) begin
            pass_q <= '0;
            lane   <= '0;
            for (int i = 0; i < NUM_LANES; i++) tap_arr[i] <= '0;
          end
        end
        S_LOAD: begin
          tap      <= '0;
          r_valid  <= 1'b0;
          e1_valid <= 1'b0;
          fail     <= 1'b0;
        end
        S_CLEAR: settle_cnt <= '0;
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SC_W'(1);
          smp_cnt    <= '0;
        end
        S_SAMPLE: begin
          smp_cnt <= smp_cnt + SM_W'(1);
          if (smp_cnt == '0) begin
            w0        <= rx_act;
            mismatch  <= 1'b0;
            flag_seen <= flag_act;
          end else begin
            if (rx_act != w0) mismatch <= 1'b1;
            if (flag_act) flag_seen <= 1'b1;
          end
        end
        S_EVAL: begin
          if (!r_valid) begin
            if (tap_stable) begin
              r_valid <= 1'b1;
              r_word  <= w0;
            end
          end else if (!e1_valid) begin
            if (!(tap_stable && (w0 == r_word))) begin
              e1_valid <= 1'b1;
              e1_tap   <= tap;
            end
          end else if (e2_hit) begin
            target <= midpoint(e1_tap, tap);
          end
        end
        S_STEP: tap <= tap + TAP_W'(1);
        S_RELOAD: begin
          mv_cnt  <= '0;
          mv_wait <= '0;
        end
        S_MOVE_TO: begin
          if (mv_pulse) begin
            mv_cnt  <= mv_cnt + TAP_W'(1);
            mv_wait <= SETTLE_LAST;
          end else if (mv_wait != '0) begin
            mv_wait <= mv_wait - SC_W'(1);
          end
        end
        S_NEXT_LANE: begin
          pass_q[lane]  <= !fail;
          tap_arr[lane] <= fail ? '0 : target;
          if (lane != LANE_LAST) lane <= lane + LANE_W'(1);
        end
        default: ;
      endcase
      if (fail_set) fail <= 1'b1;
    end
  end

endmodule

// File: doc/ddrphy_bclk_train_ctrl.md
Name: ddrphy_bclk_train_ctrl

Overview:
Parametrised training controller for NUM_LANES BCLK-training IOD lanes in the DDR4 PHY block. For each lane in turn it sweeps the dynamic RX delay line, classifies every tap from RX_DATA and the eye-monitor flags, and locates the BCLK transition region. It then parks the delay line at the centre of that region. It sits in the fabric between the PHY sequencer and the per-lane IOD delay-line and eye-monitor controls.

Parameters:
NUM_LANES, 2, number of IOD lanes trained (1..8)
RX_WIDTH, 8, deserialised RX_DATA bits per lane
MAX_TAPS, 128, taps swept per lane; TAP_W = clog2(MAX_TAPS)
SETTLE_CYCLES, 8, wait cycles after each delay change before sampling (>=1)
SAMPLES, 16, RX words compared per tap (>=2)

Ports:
FAB_CLK  in  1  sole clock
RESET_N  in  1  synchronous active-low reset
TRAIN_START  in  1  one-cycle start pulse; ignored while busy
TRAIN_BUSY  out  1  high from the cycle after an accepted start until DONE
TRAIN_DONE  out  1  one-cycle pulse when all lanes are finished
LANE_PASS  out  NUM_LANES  per-lane result, valid at DONE
LANE_TAP  out  NUM_LANES*TAP_W  final tap per lane, valid at DONE
RX_DATA  in  NUM_LANES*RX_WIDTH  IOD deserialised data
EYE_MONITOR_EARLY  in  NUM_LANES  IOD eye flags, sticky until cleared
EYE_MONITOR_LATE  in  NUM_LANES  IOD eye flags
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD delay saturation
DELAY_LINE_MOVE  out  NUM_LANES  one-cycle step pulse
DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment
DELAY_LINE_LOAD  out  NUM_LANES  one-cycle reload to static delay (tap 0)
EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle flag clear

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values: all outputs 0; DIRECTION 0; LANE_PASS 0; LANE_TAP 0; FSM in IDLE; lane index 0.
- Reset asserted in any state aborts training within one cycle. No partial results are kept.
- Only the active lane's bits of MOVE, LOAD and CLEAR_FLAGS ever pulse. All other lanes' bits stay 0.
- DIRECTION is driven 1 for the active lane throughout training.
- FSM states and transitions:
  - IDLE: on TRAIN_START go to LOAD and clear LANE_PASS and LANE_TAP.
  - LOAD: pulse LOAD, set tap counter to 0, then go to CLEAR.
  - CLEAR: pulse CLEAR_FLAGS, then go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: capture the first word W0, then compare the next SAMPLES-1 words to it. OR the EARLY and LATE flags over the window.
  - EVAL: classify the tap as STABLE(W0) if all words are equal and no flag was set; otherwise UNSTABLE.
  - STEP: pulse MOVE, increment the tap counter, then go to CLEAR.
  - RELOAD: pulse LOAD.
  - MOVE_TO: issue target pulses of MOVE, spaced SETTLE_CYCLES apart.
  - NEXT_LANE: record the lane result, then advance to the next lane or go to DONE.
  - DONE: pulse TRAIN_DONE for one cycle, then return to IDLE.
- Edge search, performed in EVAL:
  - R is the word of the first STABLE tap.
  - E1 is the first tap after R's region that is not STABLE(R).
  - E2 is the first tap after E1 that is STABLE with a word different from R.
  - When E2 is found, target = E1 + ((E2 - E1) >> 1), using floor arithmetic at TAP_W+1 bits. Then go to RELOAD.
- Failure is any of the following:
  - The tap counter reaches MAX_TAPS-1 with E2 not found.
  - OUT_OF_RANGE is seen high for the active lane in any state.
  - On failure: LANE_PASS = 0, LANE_TAP = 0, and the lane is reloaded (LOAD pulse) with no MOVE pulses.
- Pass: LANE_PASS = 1 and LANE_TAP = target. In MOVE_TO, target = 0 issues no MOVE pulses.
- Boundary cases:
  - Tap 0 UNSTABLE: R is taken from a later tap.
  - Edge exactly at tap 0: E1 is undefined until R exists.
  - TRAIN_START while BUSY is ignored.
  - TRAIN_START in the same cycle as DONE is ignored.
  - TRAIN_BUSY falls in the same cycle that TRAIN_DONE pulses.

Test Plan:
- NUM_LANES=2. Lane0 RX=0x55 for taps 0-39, noisy for 40-45, 0xAA from tap 46 -> LANE_PASS[0]=1, LANE_TAP[0]=43, exactly 43 MOVE pulses after the final LOAD.
- Lane1 constant 0x55 for all 128 taps -> LANE_PASS[1]=0, LANE_TAP[1]=0, final LOAD with no MOVE pulses, TRAIN_DONE pulses once.
- EARLY flag forced high at taps 10-11 only, clean word change 0x0F->0xF0 at tap 12 -> E1=10, E2=12, LANE_TAP=11.
- OUT_OF_RANGE asserted on lane0 at tap 20 -> lane0 fails immediately, lane1 training starts next.
- RESET_N low during lane1 SAMPLE -> next cycle all outputs 0 and FSM in IDLE. A new TRAIN_START completes normally.
- TRAIN_START pulsed while BUSY -> no restart; the results match a run without the extra pulse.
